// File: rtl/rgb_stream_timing_gen_if.sv
// Pixel stream handshake between the DSI receive path (master) and the
// raster timing generator (slave).
interface rgb_stream_timing_gen_if;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;

    modport master (output pixel_data, output pixel_valid, input pixel_ready);
    modport slave  (input pixel_data, input pixel_valid, output pixel_ready);
endinterface

// File: rtl/rgb_stream_timing_gen.sv
// Raster timing generator with RGB888/666/565 pixel unpacker.
// Optional macro COLOR_BAR_FILL_EN: underflow slots show an 8-bar pattern instead of black.
module rgb_stream_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int COMP_W   = 8,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic [1:0]            i_fmt,
    rgb_stream_timing_gen_if.slave pix,
    output logic [COMP_W-1:0]     o_r,
    output logic [COMP_W-1:0]     o_g,
    output logic [COMP_W-1:0]     o_b,
    output logic                  o_de,
    output logic                  o_hsync,
    output logic                  o_vsync,
    output logic                  o_frame_start,
    output logic                  o_underflow,
    input  logic                  i_underflow_clr
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [HW-1:0]     r_h_cnt;
    logic [VW-1:0]     r_v_cnt;
    logic [1:0]        r_fmt_q;
    int                w_h;
    int                w_v;
    logic              w_origin;
    logic              w_de_i;
    logic              w_hs_i;
    logic              w_vs_i;
    logic [1:0]        w_fmt_eff;
    logic [COMP_W-1:0] w_pix_r, w_pix_g, w_pix_b;
    logic [COMP_W-1:0] w_fill_r, w_fill_g, w_fill_b;

    // Left-align a fw-bit field and fill the low bits by cycling its MSBs.
    function automatic logic [COMP_W-1:0] f_expand(input logic [7:0] val, input int fw);
        logic [COMP_W-1:0] res;
        res = '0;
        for (int i = 0; i < COMP_W; i++) begin
            res[i] = val[3'(fw - 1 - ((COMP_W - 1 - i) % fw))];
        end
        return res;
    endfunction

    assign w_h      = int'(r_h_cnt);
    assign w_v      = int'(r_v_cnt);
    assign w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_de_i   = (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
    assign w_hs_i   = (w_h >= H_ACTIVE + H_FP) && (w_h < H_ACTIVE + H_FP + H_SYNC);
    assign w_vs_i   = (w_v >= V_ACTIVE + V_FP) && (w_v < V_ACTIVE + V_FP + V_SYNC);

    assign pix.pixel_ready = i_enable && w_de_i;

    // The format is latched at the frame origin; the origin pixel itself uses the new value.
    assign w_fmt_eff = w_origin ? i_fmt : r_fmt_q;

    always_comb begin
        w_pix_r = '0;
        w_pix_g = '0;
        w_pix_b = '0;
        case (w_fmt_eff)
            2'd1: begin
                w_pix_r = f_expand({2'b00, pix.pixel_data[17:12]}, 6);
                w_pix_g = f_expand({2'b00, pix.pixel_data[11:6]}, 6);
                w_pix_b = f_expand({2'b00, pix.pixel_data[5:0]}, 6);
            end
            2'd2: begin
                w_pix_r = f_expand({3'b000, pix.pixel_data[15:11]}, 5);
                w_pix_g = f_expand({2'b00, pix.pixel_data[10:5]}, 6);
                w_pix_b = f_expand({3'b000, pix.pixel_data[4:0]}, 5);
            end
            default: begin
                w_pix_r = f_expand(pix.pixel_data[23:16], 8);
                w_pix_g = f_expand(pix.pixel_data[15:8], 8);
                w_pix_b = f_expand(pix.pixel_data[7:0], 8);
            end
        endcase
    end

`ifdef COLOR_BAR_FILL_EN
    // Bar order white..black is exactly the bitwise inverse of the bar index as {g,r,b}.
    logic [2:0] w_bar;
    assign w_bar    = 3'((w_h * 8) / H_ACTIVE);
    assign w_fill_r = {COMP_W{~w_bar[1]}};
    assign w_fill_g = {COMP_W{~w_bar[2]}};
    assign w_fill_b = {COMP_W{~w_bar[0]}};
`else
    assign w_fill_r = '0;
    assign w_fill_g = '0;
    assign w_fill_b = '0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_fmt_q       <= 2'd0;
            o_r           <= '0;
            o_g           <= '0;
            o_b           <= '0;
            o_de          <= 1'b0;
            o_hsync       <= ~HS_POL;
            o_vsync       <= ~VS_POL;
            o_frame_start <= 1'b0;
            o_underflow   <= 1'b0;
        end else begin
            if (w_origin) begin
                r_fmt_q <= i_fmt;
            end
            if (!i_enable) begin
                r_h_cnt       <= '0;
                r_v_cnt       <= '0;
                o_r           <= '0;
                o_g           <= '0;
                o_b           <= '0;
                o_de          <= 1'b0;
                o_hsync       <= ~HS_POL;
                o_vsync       <= ~VS_POL;
                o_frame_start <= 1'b0;
            end else begin
                if (r_h_cnt == H_LAST) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
                end else begin
                    r_h_cnt <= r_h_cnt + 1'b1;
                end
                o_de          <= w_de_i;
                o_hsync       <= w_hs_i ? HS_POL : ~HS_POL;
                o_vsync       <= w_vs_i ? VS_POL : ~VS_POL;
                o_frame_start <= w_origin;
                if (w_de_i && pix.pixel_valid) begin
                    o_r <= w_pix_r;
                    o_g <= w_pix_g;
                    o_b <= w_pix_b;
                end else if (w_de_i) begin
                    o_r <= w_fill_r;
                    o_g <= w_fill_g;
                    o_b <= w_fill_b;
                end else begin
                    o_r <= '0;
                    o_g <= '0;
                    o_b <= '0;
                end
                if (w_de_i && !pix.pixel_valid) begin
                    o_underflow <= 1'b1;
                end else if (i_underflow_clr) begin
                    o_underflow <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_rgb_stream_timing_gen.sv
// Scoreboard bench: 8x6 raster (4 active pixels x 3 active lines), second instance with inverted sync polarity.
module tb_rgb_stream_timing_gen;
    logic       clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_enable = 1'b0;
    logic [1:0] i_fmt = 2'd0;
    logic       i_uf_clr = 1'b0;

    logic [7:0] r0, g0, b0, r1, g1, b1;
    logic de0, hs0, vs0, fs0, uf0, de1, hs1, vs1, fs1, uf1;

    rgb_stream_timing_gen_if pix0 ();
    rgb_stream_timing_gen_if pix1 ();

    always #5 clk = ~clk;

    rgb_stream_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .COMP_W(8), .HS_POL(1'b1), .VS_POL(1'b1))
    u0 (.i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_fmt(i_fmt), .pix(pix0.slave),
        .o_r(r0), .o_g(g0), .o_b(b0), .o_de(de0), .o_hsync(hs0), .o_vsync(vs0),
        .o_frame_start(fs0), .o_underflow(uf0), .i_underflow_clr(i_uf_clr));

    rgb_stream_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .COMP_W(8), .HS_POL(1'b0), .VS_POL(1'b0))
    u1 (.i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_fmt(i_fmt), .pix(pix1.slave),
        .o_r(r1), .o_g(g1), .o_b(b1), .o_de(de1), .o_hsync(hs1), .o_vsync(vs1),
        .o_frame_start(fs1), .o_underflow(uf1), .i_underflow_clr(i_uf_clr));

    typedef struct { bit de; bit hs; bit vs; bit fs; bit uf; } tim_t;
    typedef struct { logic [7:0] r; logic [7:0] g; logic [7:0] b; } pix_t;

    tim_t tq[$];
    pix_t pq[$];
    int tests = 0;
    int fails = 0;
    int pos = 0;
    logic [1:0] mfmt = 2'd0;
    bit muf = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ex8(input logic [7:0] f, input int w);
        case (w)
            6:       return {f[5:0], f[5:4]};
            5:       return {f[4:0], f[4:2]};
            default: return f;
        endcase
    endfunction

    function automatic pix_t unpack(input logic [23:0] d, input logic [1:0] fm);
        pix_t p;
        case (fm)
            2'd1:    p = '{ex8({2'b0, d[17:12]}, 6), ex8({2'b0, d[11:6]}, 6), ex8({2'b0, d[5:0]}, 6)};
            2'd2:    p = '{ex8({3'b0, d[15:11]}, 5), ex8({2'b0, d[10:5]}, 6), ex8({3'b0, d[4:0]}, 5)};
            default: p = '{d[23:16], d[15:8], d[7:0]};
        endcase
        return p;
    endfunction

    // Fill colour per active column: with 4 active pixels the bars are 0,2,4,6.
    function automatic pix_t fill(input int col);
        pix_t p;
`ifdef COLOR_BAR_FILL_EN
        case (col)
            0:       p = '{8'hFF, 8'hFF, 8'hFF};
            1:       p = '{8'h00, 8'hFF, 8'hFF};
            2:       p = '{8'hFF, 8'h00, 8'hFF};
            default: p = '{8'h00, 8'h00, 8'hFF};
        endcase
`else
        p = '{8'h00, 8'h00, 8'h00};
        if (col > 3) p.r = 8'h01;
`endif
        return p;
    endfunction

    // One clock of stimulus; called just after a rising edge, returns just after the next one.
    task automatic cyc(input bit en, input bit vld, input logic [23:0] d, input logic [1:0] f, input bit clr);
        tim_t t;
        pix_t p;
        bit act;
        int col, line;
        i_enable = en;
        pix0.pixel_valid = vld;
        pix1.pixel_valid = vld;
        pix0.pixel_data = d;
        pix1.pixel_data = d;
        i_fmt = f;
        i_uf_clr = clr;
        col = pos % 8;
        line = pos / 8;
        act = en && (col < 4) && (line < 3);
        #1;
        chk("pixel_ready", {31'd0, pix0.pixel_ready}, {31'd0, act});
        chk("pixel_ready_pol0", {31'd0, pix1.pixel_ready}, {31'd0, act});
        if (pos == 0) mfmt = f;
        t = '{default: 1'b0};
        p = '{8'h00, 8'h00, 8'h00};
        if (en) begin
            t.de = act;
            t.hs = (col == 5) || (col == 6);
            t.vs = (line == 4);
            t.fs = (pos == 0);
            if (act) p = vld ? unpack(d, mfmt) : fill(col);
            if (act && !vld) muf = 1'b1;
            else if (clr) muf = 1'b0;
            pos = (pos + 1) % 48;
        end else begin
            pos = 0;
        end
        t.uf = muf;
        @(posedge clk);
        tq.push_back(t);
        if (act) pq.push_back(p);
        #1;
    endtask

    always @(negedge clk) begin
        tim_t t;
        pix_t p;
        if (!i_reset && tq.size() > 0) begin
            t = tq.pop_front();
            chk("de", {31'd0, de0}, {31'd0, t.de});
            chk("hsync", {31'd0, hs0}, {31'd0, t.hs});
            chk("vsync", {31'd0, vs0}, {31'd0, t.vs});
            chk("frame_start", {31'd0, fs0}, {31'd0, t.fs});
            chk("underflow", {31'd0, uf0}, {31'd0, t.uf});
            chk("de_pol0", {31'd0, de1}, {31'd0, t.de});
            chk("hsync_pol0", {31'd0, hs1}, {31'd0, !t.hs});
            chk("vsync_pol0", {31'd0, vs1}, {31'd0, !t.vs});
            if (de0) begin
                if (pq.size() == 0) begin
                    chk("pixel_expected", 32'd0, 32'd1);
                end else begin
                    p = pq.pop_front();
                    chk("rgb", {8'd0, r0, g0, b0}, {8'd0, p.r, p.g, p.b});
                end
            end else begin
                chk("rgb_idle", {8'd0, r0, g0, b0}, 32'd0);
            end
        end
    end

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_rgb"}, {8'd0, r0, g0, b0}, 32'd0);
        chk({nm, "_de"}, {31'd0, de0}, 32'd0);
        chk({nm, "_fs"}, {31'd0, fs0}, 32'd0);
        chk({nm, "_uf"}, {31'd0, uf0}, 32'd0);
        chk({nm, "_hsync"}, {31'd0, hs0}, 32'd0);
        chk({nm, "_vsync"}, {31'd0, vs0}, 32'd0);
        chk({nm, "_hsync_pol0"}, {31'd0, hs1}, 32'd1);
        chk({nm, "_vsync_pol0"}, {31'd0, vs1}, 32'd1);
    endtask

    initial begin
        pix0.pixel_valid = 1'b0;
        pix1.pixel_valid = 1'b0;
        pix0.pixel_data = 24'd0;
        pix1.pixel_data = 24'd0;
        #1 i_reset = 1'b1;
        #1 chk_reset_vals("reset");
        @(posedge clk); #1;
        i_reset = 1'b0;

        // Format 0, switched to format 2 mid-frame: rest of this frame still decodes as RGB888.
        for (int i = 0; i < 48; i++)
            if (i < 10) cyc(1, 1, 24'hFF8001, 2'd0, 0);
            else        cyc(1, 1, 24'h00F81F, 2'd2, 0);
        // Format 2 frame, switched to format 1 mid-frame.
        for (int i = 0; i < 48; i++)
            if (i < 10) cyc(1, 1, 24'h00F81F, 2'd2, 0);
            else        cyc(1, 1, 24'h03F000, 2'd1, 0);
        for (int i = 0; i < 48; i++) cyc(1, 1, 24'h03F000, 2'd1, 0);

        // Underflow: drop, clear, drop with simultaneous clear, clear.
        for (int i = 0; i < 48; i++) begin
            case (i)
                9:       cyc(1, 0, 24'h123456, 2'd0, 0);
                12:      cyc(1, 1, 24'h123456, 2'd0, 1);
                17:      cyc(1, 0, 24'h123456, 2'd0, 1);
                22:      cyc(1, 1, 24'h123456, 2'd0, 1);
                default: cyc(1, 1, 24'h123456, 2'd0, 0);
            endcase
        end

        // Enable low at h=2, v=1, then restart from the origin.
        for (int i = 0; i < 10; i++) cyc(1, 1, 24'hA5C33C, 2'd0, 0);
        for (int i = 0; i < 4; i++)  cyc(0, 1, 24'hA5C33C, 2'd0, 0);
        for (int i = 0; i < 48; i++) cyc(1, 1, 24'hA5C33C, 2'd0, 0);

        // Asynchronous reset in the middle of an active line.
        for (int i = 0; i < 9; i++) cyc(1, 1, 24'h0F1E2D, 2'd0, 0);
        chk("pre_reset_de", {31'd0, de0}, 32'd1);
        #2 i_reset = 1'b1;
        #1 chk_reset_vals("async_reset");
        tq.delete();
        pq.delete();
        pos = 0;
        muf = 1'b0;
        mfmt = 2'd0;
        @(posedge clk); #1;
        i_reset = 1'b0;
        for (int i = 0; i < 48; i++) cyc(1, 1, 24'h0F1E2D, 2'd0, 0);

        @(negedge clk); #1;
        chk("timing_queue_drained", tq.size(), 32'd0);
        chk("pixel_queue_drained", pq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
